vocab_token_encoder: RTL and testbench

Parametrised successor to the single-vocab word encoder. It scans a zero-delimited word stream in input memory and looks each word up in a fixed-stride vocab memory. For each word it writes a token ID to output memory, or, in copy mode, copies unknown words verbatim. All three memories are external synchronous-read RAMs, so the block sits between the input/vocab/output srams and the top-level sequencer.

---
 rtl/vocab_token_encoder_if.sv | 35 +++
 rtl/vocab_token_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_vocab_token_encoder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vocab_token_encoder_if.sv
// Sequencer handshake plus the input, vocab and output sram ports of the token encoder.
// The master side drives start/copy_mode and returns the sram read data.
interface vocab_token_encoder_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_ADDR_WIDTH  = 6,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int VOC_ADDR_WIDTH = 5
);
  logic                      start;
  logic                      copy_mode;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [IN_ADDR_WIDTH-1:0]  in_addr;
  logic [DATA_WIDTH-1:0]     in_rdata;
  logic [VOC_ADDR_WIDTH-1:0] voc_addr;
  logic [DATA_WIDTH-1:0]     voc_rdata;
  logic [OUT_ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0]     out_wdata;
  logic                      out_we;
  logic [OUT_ADDR_WIDTH-1:0] token_count;
  logic [OUT_ADDR_WIDTH-1:0] unk_count;

  modport master (
    output start, copy_mode, in_rdata, voc_rdata,
    input  busy, done, error, in_addr, voc_addr, out_addr, out_wdata, out_we,
           token_count, unk_count
  );

  modport slave (
    input  start, copy_mode, in_rdata, voc_rdata,
    output busy, done, error, in_addr, voc_addr, out_addr, out_wdata, out_we,
           token_count, unk_count
  );
endinterface

// File: rtl/vocab_token_encoder.sv
// Scans a zero-delimited word stream, looks each word up in a fixed-stride vocab sram and
// writes token IDs (or verbatim copies of unknown words) to the output sram.
module vocab_token_encoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_ADDR_WIDTH  = 6,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int VOCAB_SIZE     = 8,
  parameter int MAX_LEN        = 4,
  parameter int VOC_ADDR_WIDTH = $clog2(VOCAB_SIZE * MAX_LEN)
) (
  input logic                  clk,
  input logic                  rst_n,
  vocab_token_encoder_if.slave bus
);
  localparam int ENTRY_W = (VOCAB_SIZE > 1) ? $clog2(VOCAB_SIZE) : 1;
  localparam int K_W     = $clog2(MAX_LEN + 1);
  localparam logic [IN_ADDR_WIDTH-1:0]  IN_LAST    = '1;
  localparam logic [OUT_ADDR_WIDTH-1:0] OUT_LAST   = '1;
  localparam logic [DATA_WIDTH-1:0]     UNK_ID     = '1;
  localparam logic [ENTRY_W-1:0]        LAST_ENTRY = ENTRY_W'(VOCAB_SIZE - 1);
  localparam logic [K_W-1:0]            K_END      = K_W'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_WSTART, S_WCHK, S_CMP, S_MISS, S_MATCH, S_UNKNOWN, S_COPY, S_SKIP, S_DONE
  } state_e;

  state_e                    state_q;
  logic                      copyMode_q;
  logic [IN_ADDR_WIDTH-1:0]  wBase_q;
  logic [OUT_ADDR_WIDTH-1:0] oPtr_q;
  logic                      oFull_q;
  logic [ENTRY_W-1:0]        entry_q;
  logic [K_W-1:0]            issueK_q;
  logic                      issueV_q;
  logic [K_W-1:0]            pendK_q;
  logic [IN_ADDR_WIDTH-1:0]  pendAddr_q;
  logic                      pendV_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic [IN_ADDR_WIDTH-1:0]  inAddr_q;
  logic [VOC_ADDR_WIDTH-1:0] vocAddr_q;
  logic [OUT_ADDR_WIDTH-1:0] outAddr_q;
  logic [DATA_WIDTH-1:0]     outWdata_q;
  logic                      outWe_q;
  logic [OUT_ADDR_WIDTH-1:0] tokenCount_q;
  logic [OUT_ADDR_WIDTH-1:0] unkCount_q;

  logic [K_W-1:0] kNext_d;
  logic           cmpHit_d;
  logic           cmpMiss_d;

  function automatic logic [VOC_ADDR_WIDTH-1:0] vocAddr(input logic [ENTRY_W-1:0] e,
                                                       input logic [K_W-1:0] k);
    return VOC_ADDR_WIDTH'(32'(e) * MAX_LEN + 32'(k));
  endfunction

  assign kNext_d = issueK_q + K_W'(1);

  // Judges the char pair returned for the read issued last cycle; k==MAX_LEN only checks
  // that the word ends right after a full-length entry.
  always_comb begin
    cmpHit_d  = 1'b0;
    cmpMiss_d = 1'b0;
    if (pendV_q) begin
      if (pendK_q == K_END) begin
        cmpHit_d  = (bus.in_rdata == '0);
        cmpMiss_d = (bus.in_rdata != '0);
      end else if (bus.in_rdata != bus.voc_rdata) begin
        cmpMiss_d = 1'b1;
      end else if (bus.in_rdata == '0) begin
        cmpHit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      copyMode_q   <= 1'b0;
      wBase_q      <= '0;
      oPtr_q       <= '0;
      oFull_q      <= 1'b0;
      entry_q      <= '0;
      issueK_q     <= '0;
      issueV_q     <= 1'b0;
      pendK_q      <= '0;
      pendAddr_q   <= '0;
      pendV_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      inAddr_q     <= '0;
      vocAddr_q    <= '0;
      outAddr_q    <= '0;
      outWdata_q   <= '0;
      outWe_q      <= 1'b0;
      tokenCount_q <= '0;
      unkCount_q   <= '0;
    end else begin
      outWe_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            copyMode_q   <= bus.copy_mode;
            wBase_q      <= '0;
            oPtr_q       <= '0;
            oFull_q      <= 1'b0;
            tokenCount_q <= '0;
            unkCount_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            inAddr_q     <= '0;
            state_q      <= S_WSTART;
          end
        end
        S_WSTART: state_q <= S_WCHK;
        S_WCHK: begin
          if (bus.in_rdata == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            entry_q   <= '0;
            inAddr_q  <= wBase_q;
            vocAddr_q <= vocAddr('0, '0);
            issueK_q  <= '0;
            issueV_q  <= 1'b1;
            pendV_q   <= 1'b0;
            state_q   <= S_CMP;
          end
        end
        S_CMP: begin
          pendV_q <= issueV_q;
          pendK_q <= issueK_q;
          if (issueV_q) begin
            if (issueK_q == K_END) begin
              issueV_q <= 1'b0;
            end else begin
              issueK_q <= kNext_d;
              inAddr_q <= wBase_q + IN_ADDR_WIDTH'(kNext_d);
              if (kNext_d < K_END) vocAddr_q <= vocAddr(entry_q, kNext_d);
            end
          end
          if (cmpHit_d || cmpMiss_d) begin
            pendV_q  <= 1'b0;
            issueV_q <= 1'b0;
            state_q  <= cmpHit_d ? S_MATCH : S_MISS;
          end
        end
        S_MISS: begin
          if (entry_q == LAST_ENTRY) begin
            state_q <= S_UNKNOWN;
          end else begin
            entry_q   <= entry_q + ENTRY_W'(1);
            inAddr_q  <= wBase_q;
            vocAddr_q <= vocAddr(entry_q + ENTRY_W'(1), '0);
            issueK_q  <= '0;
            issueV_q  <= 1'b1;
            state_q   <= S_CMP;
          end
        end
        S_MATCH, S_UNKNOWN: begin
          if (state_q == S_UNKNOWN && copyMode_q) begin
            tokenCount_q <= tokenCount_q + OUT_ADDR_WIDTH'(1);
            unkCount_q   <= unkCount_q + OUT_ADDR_WIDTH'(1);
            inAddr_q     <= wBase_q;
            pendV_q      <= 1'b0;
            state_q      <= S_COPY;
          end else if (oFull_q) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            outAddr_q    <= oPtr_q;
            outWdata_q   <= (state_q == S_MATCH) ? DATA_WIDTH'(entry_q) : UNK_ID;
            outWe_q      <= 1'b1;
            oPtr_q       <= oPtr_q + OUT_ADDR_WIDTH'(1);
            oFull_q      <= (oPtr_q == OUT_LAST);
            tokenCount_q <= tokenCount_q + OUT_ADDR_WIDTH'(1);
            if (state_q == S_UNKNOWN) unkCount_q <= unkCount_q + OUT_ADDR_WIDTH'(1);
            inAddr_q     <= wBase_q;
            pendV_q      <= 1'b0;
            state_q      <= S_SKIP;
          end
        end
        // SKIP and COPY rescan the word from its base, one read per cycle; the last input
        // address can never hold a char that is followed by a stream terminator.
        S_SKIP, S_COPY: begin
          inAddr_q   <= inAddr_q + IN_ADDR_WIDTH'(1);
          pendAddr_q <= inAddr_q;
          pendV_q    <= 1'b1;
          if (pendV_q) begin
            if (pendAddr_q == IN_LAST || (state_q == S_COPY && oFull_q)) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pendV_q <= 1'b0;
              state_q <= S_DONE;
            end else begin
              if (state_q == S_COPY) begin
                outAddr_q  <= oPtr_q;
                outWdata_q <= bus.in_rdata;
                outWe_q    <= 1'b1;
                oPtr_q     <= oPtr_q + OUT_ADDR_WIDTH'(1);
                oFull_q    <= (oPtr_q == OUT_LAST);
              end
              if (bus.in_rdata == '0) begin
                wBase_q  <= pendAddr_q + IN_ADDR_WIDTH'(1);
                inAddr_q <= pendAddr_q + IN_ADDR_WIDTH'(1);
                pendV_q  <= 1'b0;
                state_q  <= S_WSTART;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.in_addr     = inAddr_q;
  assign bus.voc_addr    = vocAddr_q;
  assign bus.out_addr    = outAddr_q;
  assign bus.out_wdata   = outWdata_q;
  assign bus.out_we      = outWe_q;
  assign bus.token_count = tokenCount_q;
  assign bus.unk_count   = unkCount_q;
endmodule

// File: tb/tb_vocab_token_encoder.sv
// Directed bench for vocab_token_encoder: a word-level model predicts every output write,
// the final counts and the error flag; a second instance with a 1-bit output space hits overflow.
module tb_vocab_token_encoder;
  localparam int IN_DEPTH = 64;
  localparam int IN_LAST  = IN_DEPTH - 1;
  localparam int VOC_N    = 8;
  localparam int MAXL     = 4;
  localparam int VOC_AW   = $clog2(VOC_N * MAXL);
  localparam int BUDGET   = 3000;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] inMem[IN_DEPTH];
  logic [7:0] vocMem[VOC_N * MAXL];
  logic [7:0] outMem[64];
  logic [7:0] outMemOvf[2];

  wr_t expMain[$];
  wr_t expOvf[$];
  wr_t wMain;
  wr_t wOvf;
  wr_t mWr[$];
  int  mTok, mUnk, mErr;
  int  checks = 0;
  int  errors = 0;
  int  lastCycles;

  vocab_token_encoder_if #(.DATA_WIDTH(8), .IN_ADDR_WIDTH(6), .OUT_ADDR_WIDTH(6),
                           .VOC_ADDR_WIDTH(VOC_AW)) busMain ();
  vocab_token_encoder_if #(.DATA_WIDTH(8), .IN_ADDR_WIDTH(6), .OUT_ADDR_WIDTH(1),
                           .VOC_ADDR_WIDTH(VOC_AW)) busOvf ();

  vocab_token_encoder #(.DATA_WIDTH(8), .IN_ADDR_WIDTH(6), .OUT_ADDR_WIDTH(6),
                        .VOCAB_SIZE(VOC_N), .MAX_LEN(MAXL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busMain)
  );

  vocab_token_encoder #(.DATA_WIDTH(8), .IN_ADDR_WIDTH(6), .OUT_ADDR_WIDTH(1),
                        .VOCAB_SIZE(VOC_N), .MAX_LEN(MAXL)) dutOvf (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busOvf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    busMain.in_rdata  <= inMem[busMain.in_addr];
    busMain.voc_rdata <= vocMem[busMain.voc_addr];
    busOvf.in_rdata   <= inMem[busOvf.in_addr];
    busOvf.voc_rdata  <= vocMem[busOvf.voc_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every output write of either instance is compared with the model's next predicted write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busMain.out_we) begin
        if (expMain.size() == 0) begin
          checkOutput("main.unexpectedWrite", int'(busMain.out_addr), -1);
        end else begin
          wMain = expMain.pop_front();
          checkOutput("main.wrAddr", int'(busMain.out_addr), wMain.addr);
          checkOutput("main.wrData", int'(busMain.out_wdata), wMain.data);
        end
        outMem[busMain.out_addr] = busMain.out_wdata;
      end
      if (busOvf.out_we) begin
        if (expOvf.size() == 0) begin
          checkOutput("ovf.unexpectedWrite", int'(busOvf.out_addr), -1);
        end else begin
          wOvf = expOvf.pop_front();
          checkOutput("ovf.wrAddr", int'(busOvf.out_addr), wOvf.addr);
          checkOutput("ovf.wrData", int'(busOvf.out_wdata), wOvf.data);
        end
        outMemOvf[busOvf.out_addr] = busOvf.out_wdata;
      end
      checkOutput("main.busyDoneExclusive", int'(busMain.busy & busMain.done), 0);
    end
  end

  task automatic setVocab(input int e, input string s);
    for (int i = 0; i < MAXL; i++) vocMem[e * MAXL + i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // '|' in the text stands for a 0 byte; addresses past the text get the fill byte.
  task automatic loadInput(input string text, input logic [7:0] fill);
    for (int i = 0; i < IN_DEPTH; i++) begin
      if (i < text.len()) inMem[i] = (text[i] == "|") ? 8'h00 : text[i];
      else inMem[i] = fill;
    end
  endtask

  function automatic bit entryMatches(input int e, input int word[$]);
    int len = word.size();
    if (len > MAXL) return 1'b0;
    for (int i = 0; i < len; i++) if (int'(vocMem[e * MAXL + i]) != word[i]) return 1'b0;
    if (len < MAXL && vocMem[e * MAXL + len] != 8'h00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic buildModel(input bit cm, input int outW);
    int  p = 0, optr = 0, tok = 0, unk = 0, id = 0, a = 0;
    int  maxOut = (1 << outW) - 1;
    bit  full = 0, term, found, stop = 0;
    int  word[$];
    mWr.delete();
    mErr = 0;
    while (!stop && inMem[p] != 8'h00) begin
      word.delete();
      term = 0;
      for (int i = p; i < IN_LAST; i++) begin
        if (inMem[i] == 8'h00) begin
          term = 1;
          break;
        end
        word.push_back(int'(inMem[i]));
      end
      found = 0;
      if (term) begin
        for (int e = 0; e < VOC_N; e++) begin
          if (!found && entryMatches(e, word)) begin
            found = 1;
            id = e;
          end
        end
      end
      if (!cm || found) begin
        if (full) begin
          mErr = 1;
          stop = 1;
        end else begin
          mWr.push_back('{optr, found ? id : 255});
          full = (optr == maxOut);
          optr = (optr + 1) & maxOut;
          tok++;
          if (!found) unk++;
          if (!term) begin
            mErr = 1;
            stop = 1;
          end
        end
      end else begin
        tok++;
        unk++;
        a = p;
        forever begin
          if (a == IN_LAST || full) begin
            mErr = 1;
            stop = 1;
            break;
          end
          mWr.push_back('{optr, int'(inMem[a])});
          full = (optr == maxOut);
          optr = (optr + 1) & maxOut;
          if (inMem[a] == 8'h00) break;
          a++;
        end
      end
      p = p + word.size() + 1;
    end
    mTok = tok & maxOut;
    mUnk = unk & maxOut;
  endtask

  task automatic applyStimulus(input string label, input string text, input logic [7:0] fill,
                               input bit cm, input bit useOvf);
    int cycles = 0;
    loadInput(text, fill);
    buildModel(cm, useOvf ? 1 : 6);
    foreach (mWr[i]) begin
      if (useOvf) expOvf.push_back(mWr[i]);
      else expMain.push_back(mWr[i]);
    end
    @(negedge clk);
    if (useOvf) begin
      busOvf.copy_mode = cm;
      busOvf.start     = 1'b1;
    end else begin
      busMain.copy_mode = cm;
      busMain.start     = 1'b1;
    end
    @(negedge clk);
    busMain.start = 1'b0;
    busOvf.start  = 1'b0;
    while (!(useOvf ? busOvf.done : busMain.done) && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    lastCycles = cycles + 1;
    checkOutput({label, ".finished"}, int'(cycles < BUDGET), 1);
    if (useOvf) begin
      checkOutput({label, ".tokenCount"}, int'(busOvf.token_count), mTok);
      checkOutput({label, ".unkCount"}, int'(busOvf.unk_count), mUnk);
      checkOutput({label, ".error"}, int'(busOvf.error), mErr);
      checkOutput({label, ".busy"}, int'(busOvf.busy), 0);
      checkOutput({label, ".writesLeft"}, expOvf.size(), 0);
    end else begin
      checkOutput({label, ".tokenCount"}, int'(busMain.token_count), mTok);
      checkOutput({label, ".unkCount"}, int'(busMain.unk_count), mUnk);
      checkOutput({label, ".error"}, int'(busMain.error), mErr);
      checkOutput({label, ".busy"}, int'(busMain.busy), 0);
      checkOutput({label, ".writesLeft"}, expMain.size(), 0);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    busMain.start     = 1'b0;
    busMain.copy_mode = 1'b0;
    busOvf.start      = 1'b0;
    busOvf.copy_mode  = 1'b0;
    for (int e = 0; e < VOC_N; e++) setVocab(e, "");
    setVocab(0, "a");
    setVocab(1, "bc");
    setVocab(2, "cat");
    setVocab(3, "dogs");
    loadInput("|", 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", int'(busMain.busy), 0);
    checkOutput("reset.done", int'(busMain.done), 0);
    checkOutput("reset.outWe", int'(busMain.out_we), 0);
    rst_n = 1'b1;

    applyStimulus("t1", "cat|a||", 8'h00, 1'b0, 1'b0);
    checkOutput("t1.out0", int'(outMem[0]), 2);
    checkOutput("t1.out1", int'(outMem[1]), 0);
    checkOutput("t1.tokLit", int'(busMain.token_count), 2);
    checkOutput("t1.done", int'(busMain.done), 1);

    applyStimulus("t2", "xy|bc||", 8'h00, 1'b0, 1'b0);
    checkOutput("t2.out0", int'(outMem[0]), 255);
    checkOutput("t2.out1", int'(outMem[1]), 1);
    checkOutput("t2.unkLit", int'(busMain.unk_count), 1);

    applyStimulus("t3", "xy|bc||", 8'h00, 1'b1, 1'b0);
    checkOutput("t3.out0", int'(outMem[0]), 120);
    checkOutput("t3.out1", int'(outMem[1]), 121);
    checkOutput("t3.out2", int'(outMem[2]), 0);
    checkOutput("t3.out3", int'(outMem[3]), 1);

    applyStimulus("t4", "dogs|dogsx|ca||", 8'h00, 1'b0, 1'b0);
    checkOutput("t4.out0", int'(outMem[0]), 3);
    checkOutput("t4.out1", int'(outMem[1]), 255);
    checkOutput("t4.out2", int'(outMem[2]), 255);

    applyStimulus("t5", "|", 8'h00, 1'b0, 1'b0);
    checkOutput("t5.latencyOk", int'(lastCycles <= 4), 1);
    checkOutput("t5.tokLit", int'(busMain.token_count), 0);

    applyStimulus("t6a", "", "z", 1'b0, 1'b0);
    checkOutput("t6a.errorLit", int'(busMain.error), 1);
    checkOutput("t6a.out0", int'(outMem[0]), 255);

    applyStimulus("t6b", "a|bc|xy|cat||", 8'h00, 1'b0, 1'b1);
    checkOutput("t6b.errorLit", int'(busOvf.error), 1);
    checkOutput("t6b.out0", int'(outMemOvf[0]), 0);
    checkOutput("t6b.out1", int'(outMemOvf[1]), 1);

    loadInput("dogs|cat||", 8'h00);
    @(negedge clk);
    busMain.copy_mode = 1'b0;
    busMain.start     = 1'b1;
    @(negedge clk);
    busMain.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expMain.delete();
    checkOutput("t6c.busy", int'(busMain.busy), 0);
    checkOutput("t6c.done", int'(busMain.done), 0);
    checkOutput("t6c.error", int'(busMain.error), 0);
    checkOutput("t6c.outWe", int'(busMain.out_we), 0);
    checkOutput("t6c.inAddr", int'(busMain.in_addr), 0);
    checkOutput("t6c.vocAddr", int'(busMain.voc_addr), 0);
    checkOutput("t6c.tokenCount", int'(busMain.token_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t6c.rerun", "dogs|cat||", 8'h00, 1'b0, 1'b0);
    checkOutput("t6c.out0", int'(outMem[0]), 3);
    checkOutput("t6c.out1", int'(outMem[1]), 2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
